serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor. It is the sequential successor of the team's combinational half/full-adder cells.
- Consumes two WIDTH-bit operands through a valid/ready handshake. Adds them DIGIT bits per clock through one shared digit-adder slice and a carry flop.
- Returns sum, carry-out and signed overflow through a second valid/ready handshake.
- Used in datapaths where area matters more than latency.

Parameters:
- WIDTH, 8, operand and sum width in bits.
- DIGIT, 1, bits processed per clock. Must divide WIDTH; elaboration-time assertion otherwise.
- NDIG, WIDTH/DIGIT, derived localparam: cycles per operation.

Ports:
- clk  input  1  sole clock, all flops rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and mode valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in. Ignored when sub=1.
- sub  input  1  0: a+b+cin; 1: a-b (two's complement).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry-out. For sub: 1 = no borrow.
- ovf  output  1  signed (two's-complement) overflow.

Behaviour:
- All state is updated on the rising clk edge only. There are no asynchronous paths.
- Reset (rst=1 at an edge):
  - state<=IDLE; digit counter<=0; carry<=0.
  - sum, cout, ovf <= 0; out_valid=0.
  - rst overrides every other input, including mid-BUSY and mid-DONE; any in-flight operation is discarded.
- in_ready = (state==IDLE). out_valid = (state==DONE). Both are decoded from state, with no combinational path from inputs.
- IDLE:
  - On in_valid && in_ready: latch a into A_reg and B_eff = sub ? ~b : b into B_reg.
  - Set carry <= sub ? 1 : cin; counter <= 0; store sub and the sign bits needed for ovf.
  - Go to BUSY.
- BUSY, one digit per cycle, LSB digit first:
  - The slice adds A_reg[DIGIT-1:0] + B_reg[DIGIT-1:0] + carry.
  - Result digit is shifted into the sum register from the MSB side. A_reg and B_reg shift right by DIGIT. carry <= slice carry-out.
  - counter increments. When counter==NDIG-1 on this edge, go to DONE.
- DONE:
  - sum holds the full result; cout = final carry.
  - ovf = (a[MSB]==B_eff[MSB]) && (sum[MSB]!=a[MSB]).
  - Outputs are held stable while out_ready=0. On out_ready=1, go to IDLE.
- Latency: operands accepted at edge t0 give out_valid=1 after edge t0+NDIG.
  - Throughput: one operation per NDIG+2 cycles at most. The IDLE acceptance cycle is separate from the DONE handoff, so there is no back-to-back overlap.
- in_valid is ignored outside IDLE. Operand inputs need only be stable during the acceptance cycle.
- Wrap-around: sum is truncated to WIDTH bits; the carry beyond the MSB goes only to cout.
- in_valid asserted during rst: ignored. First acceptance is possible at the first edge after rst deasserts.
- sum, cout and ovf are not cleared on leaving DONE. They are don't-care whenever out_valid=0, except after reset, when they are 0.

Decomposition:
- Package serial_adder_pkg:
  - state_t enum {IDLE, BUSY, DONE}, 2 bits.
  - A function computing NDIG and its counter width, $clog2(NDIG) with a minimum of 1.
- One sub-module, add_digit: combinational DIGIT-bit adder.
  - Ports: x, y, ci, s, co.
  - Built from the existing half-adder cells as a ripple chain.
- serial_adder instantiates add_digit once. The FSM, shift registers and counter stay in the top.

Test Plan:
- WIDTH=8, DIGIT=1: a=0xFF, b=0x01, cin=0, sub=0 -> sum=0x00, cout=1, ovf=0; out_valid rises exactly 8 edges after acceptance.
- WIDTH=8, DIGIT=1: a=0x7F, b=0x01, sub=0 -> sum=0x80, cout=0, ovf=1. Also a=0x80, b=0xFF -> sum=0x7F, cout=1, ovf=1.
- WIDTH=8, DIGIT=1: a=0x05, b=0x07, sub=1, cin=1 (ignored) -> sum=0xFE, cout=0 (borrow), ovf=0. Also a=0x07, b=0x05 -> sum=0x02, cout=1.
- WIDTH=8, DIGIT=4: a=0x3C, b=0x0F, cin=1 -> sum=0x4C, cout=0; out_valid after 2 edges.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands applied -> sum/cout/ovf stable, in_ready=0, new operands not taken. out_ready=1 -> IDLE, then the next operands are accepted.
- Reset mid-BUSY (edge 3 of 8) -> next cycle out_valid=0, in_ready=1, sum=0. A fresh operation 0x12+0x34 then yields 0x46 with no corruption from the aborted one.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
//   state_t     : controller states (2 bits)
//   calc_ndig   : cycles per operation for a given WIDTH/DIGIT
//   calc_cnt_w  : digit-counter width, never below 1 bit
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int calc_ndig(input int width, input int digit);
      return width / digit;
   endfunction

   function automatic int calc_cnt_w(input int ndig);
      return (ndig > 1) ? $clog2(ndig) : 1;
   endfunction

endpackage

// File: rtl/serial_adder_add_digit.sv
// Combinational DIGIT-bit ripple adder made of half-adder pairs.
//   x, y : digit operands
//   ci   : carry in
//   s    : digit sum
//   co   : carry out of the digit MSB
module add_digit #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co
);

   logic [DIGIT:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < DIGIT; i++) begin : g_bit
      logic ha0_s, ha0_c, ha1_c;
      // first half adder: x + y
      assign ha0_s = x[i] ^ y[i];
      assign ha0_c = x[i] & y[i];
      // second half adder: partial sum + incoming carry
      assign s[i]  = ha0_s ^ c[i];
      assign ha1_c = ha0_s & c[i];
      assign c[i+1] = ha0_c | ha1_c;
   end

   assign co = c[DIGIT];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: WIDTH-bit operands are summed DIGIT bits
// per clock through a single add_digit slice and a carry flop.
//   clk, rst               : clock, synchronous active-high reset
//   in_valid/in_ready      : operand handshake (a, b, cin, sub)
//   out_valid/out_ready    : result handshake (sum, cout, ovf)
//   sub=1 computes a-b; cin is then ignored and cout=1 means no borrow.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// BUSY  | one digit per cycle, LSB digit first
// DONE  | result held until out_ready
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NDIG = calc_ndig(WIDTH, DIGIT);
   localparam int CW   = calc_cnt_w(NDIG);

   if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("serial_adder: DIGIT must divide WIDTH");
   end

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             ovf_q, ovf_d;
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;

   logic [DIGIT-1:0]       dig_s;
   logic                   dig_co;
   logic [WIDTH+DIGIT-1:0] sum_cat;
   logic [WIDTH-1:0]       sum_shift;

   add_digit #(.DIGIT(DIGIT)) u_add_digit (
      .x  (a_q[DIGIT-1:0]),
      .y  (b_q[DIGIT-1:0]),
      .ci (carry_q),
      .s  (dig_s),
      .co (dig_co)
   );

   // New digit enters at the MSB; after NDIG shifts the LSB digit sits at bit 0.
   assign sum_cat   = {dig_s, sum_q};
   assign sum_shift = sum_cat[WIDTH+DIGIT-1:DIGIT];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      ovf_d   = ovf_q;
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = sub ? ~b : b;
               carry_d = sub ? 1'b1 : cin;
               cnt_d   = '0;
               a_msb_d = a[WIDTH-1];
               b_msb_d = sub ? ~b[WIDTH-1] : b[WIDTH-1];
               state_d = BUSY;
            end
         end
         BUSY: begin
            sum_d   = sum_shift;
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            carry_d = dig_co;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(NDIG - 1)) begin
               state_d = DONE;
               // signed overflow: like-signed operands, result sign differs
               ovf_d   = (a_msb_q == b_msb_q) && (sum_shift[WIDTH-1] != a_msb_q);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         ovf_q   <= 1'b0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         ovf_q   <= ovf_d;
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = carry_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

   typedef struct {
      logic [7:0] s;
      logic       c;
      logic       o;
      int         acc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid0, in_valid1;
   logic [7:0] a, b;
   logic       cin, sub, out_ready;

   logic       ir0, ov0, co0, of0;
   logic [7:0] s0;
   logic       ir1, ov1, co1, of1;
   logic [7:0] s1;

   int   tot = 0;
   int   bad = 0;
   int   cyc = 0;
   exp_t q0[$];
   exp_t q1[$];
   bit   seen[2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
      .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(ir0),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(ov0), .out_ready(out_ready),
      .sum(s0), .cout(co0), .ovf(of0)
   );

   serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(ir1),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(ov1), .out_ready(out_ready),
      .sum(s1), .cout(co1), .ovf(of1)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tot++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // monitor: latency on first sight of out_valid, values on handshake
   task automatic mon(input int idx, input logic ov, input logic [7:0] s,
                      input logic c, input logic o, input int ndig);
      exp_t e;
      int   qs;
      if (!ov) begin
         seen[idx] = 1'b0;
         return;
      end
      qs = (idx == 0) ? q0.size() : q1.size();
      if (qs == 0) begin
         if (!seen[idx]) begin
            tot++;
            bad++;
            $display("FAIL unexpected_result dut%0d: got sum=%0h expected none", idx, s);
            seen[idx] = 1'b1;
         end
         return;
      end
      e = (idx == 0) ? q0[0] : q1[0];
      if (!seen[idx]) begin
         chk($sformatf("latency dut%0d", idx), cyc - e.acc, ndig);
         seen[idx] = 1'b1;
      end
      if (out_ready) begin
         if (idx == 0) void'(q0.pop_front());
         else          void'(q1.pop_front());
         chk($sformatf("sum dut%0d", idx),  s, e.s);
         chk($sformatf("cout dut%0d", idx), c, e.c);
         chk($sformatf("ovf dut%0d", idx),  o, e.o);
      end
   endtask

   always @(negedge clk) begin
      mon(0, ov0, s0, co0, of0, 8);
      mon(1, ov1, s1, co1, of1, 2);
   end

   task automatic send(input int idx, input logic [7:0] ta, input logic [7:0] tb_,
                       input logic tcin, input logic tsub,
                       input logic [7:0] es, input logic ec, input logic eo);
      exp_t e;
      int   n = 0;
      while (((idx == 0) ? !ir0 : !ir1) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if ((idx == 0) ? !ir0 : !ir1) begin
         chk($sformatf("in_ready_timeout dut%0d", idx), 0, 1);
         return;
      end
      a = ta; b = tb_; cin = tcin; sub = tsub;
      if (idx == 0) in_valid0 = 1'b1;
      else          in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid0 = 1'b0;
      in_valid1 = 1'b0;
      e.s = es; e.c = ec; e.o = eo; e.acc = cyc;
      if (idx == 0) q0.push_back(e);
      else          q1.push_back(e);
   endtask

   task automatic drain(input int idx);
      int n = 0;
      while (((idx == 0) ? q0.size() : q1.size()) != 0 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk($sformatf("drain dut%0d", idx), (idx == 0) ? q0.size() : q1.size(), 0);
   endtask

   initial begin
      int n;
      rst = 1'b1;
      in_valid0 = 1'b1;
      in_valid1 = 1'b1;
      a = 8'h11; b = 8'h22; cin = 1'b0; sub = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst out_valid0", ov0, 0);
      chk("rst in_ready0", ir0, 1);
      chk("rst sum0", s0, 8'h00);
      chk("rst cout0", co0, 0);
      chk("rst ovf0", of0, 0);
      chk("rst out_valid1", ov1, 0);
      chk("rst sum1", s1, 8'h00);
      rst = 1'b0;
      in_valid0 = 1'b0;
      in_valid1 = 1'b0;
      @(posedge clk); #1;
      chk("no accept during rst", ir0, 1);

      // DIGIT=1 directed vectors
      send(0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0); drain(0);
      send(0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1); drain(0);
      send(0, 8'h80, 8'hFF, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1); drain(0);
      send(0, 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0); drain(0);
      send(0, 8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0); drain(0);
      send(0, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1); drain(0);

      // DIGIT=4 directed vectors
      send(1, 8'h3C, 8'h0F, 1'b1, 1'b0, 8'h4C, 1'b0, 1'b0); drain(1);
      send(1, 8'hF0, 8'h20, 1'b0, 1'b1, 8'hD0, 1'b1, 1'b0); drain(1);
      send(1, 8'h40, 8'h40, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1); drain(1);

      // backpressure with new operands pending
      out_ready = 1'b0;
      send(0, 8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0);
      n = 0;
      while (!ov0 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bp reach done", ov0, 1);
      a = 8'h22; b = 8'h11; cin = 1'b0; sub = 1'b0;
      in_valid0 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp in_ready", ir0, 0);
         chk("bp out_valid", ov0, 1);
         chk("bp sum", s0, 8'h31);
         chk("bp cout", co0, 0);
         chk("bp ovf", of0, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp back to idle", ir0, 1);
      chk("bp popped", q0.size(), 0);
      send(0, 8'h22, 8'h11, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0); drain(0);

      // reset during BUSY, then a clean operation
      send(0, 8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      q0.delete();
      seen[0] = 1'b0;
      chk("midrst out_valid", ov0, 0);
      chk("midrst in_ready", ir0, 1);
      chk("midrst sum", s0, 8'h00);
      send(0, 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0); drain(0);

      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
